// File: rtl/spiflashctrl_pkg.sv
// Shared types and constants for the two-requester SPI NOR flash controller.
package spiflashctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam logic [7:0] SPIFLASH_CMD_NOP   = 8'h00;
    localparam logic [7:0] SPIFLASH_CMD_READ  = 8'h01;
    localparam logic [7:0] SPIFLASH_CMD_WRITE = 8'h02;
    localparam int         SPIFLASH_FRAME_BITS = 48;

    // Frame layout on the wire, MSB first: {address, command, data}.
    function automatic logic [SPIFLASH_FRAME_BITS-1:0] spiflash_frame(
        input logic [31:0] adr,
        input logic        wr,
        input logic [7:0]  wdata
    );
        return {adr, wr ? SPIFLASH_CMD_WRITE : SPIFLASH_CMD_READ, wr ? wdata : 8'h00};
    endfunction

endpackage

// File: rtl/spiflashctrl_if.sv
// Requester-side bus of the flash controller: two request channels, shared response data.
interface spiflashctrl_if;
    logic [1:0]       ReqValid;
    logic [1:0]       ReqWrite;
    logic [1:0][31:0] ReqAdr;
    logic [1:0][7:0]  ReqWData;
    logic [1:0]       ReqReady;
    logic [1:0]       RspValid;
    logic [7:0]       RspRData;

    modport master (
        output ReqValid, ReqWrite, ReqAdr, ReqWData,
        input  ReqReady, RspValid, RspRData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAdr, ReqWData,
        output ReqReady, RspValid, RspRData
    );
endinterface

// File: rtl/spiflashctrl_rrarb.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last time is granted.
module spiflashctrl_rrarb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_valid_i,
    output logic       gnt_id_o,
    output logic [1:0] req_ready_o
);

    logic last_q, last_d;

    // Ready is gated by reset directly so it drops the instant reset asserts.
    always_comb begin
        gnt_id_o    = (&req_valid_i) ? ~last_q : req_valid_i[1];
        req_ready_o = '0;
        if (rst_ni && en_i && (|req_valid_i)) req_ready_o[gnt_id_o] = 1'b1;
        last_d = (|req_ready_o) ? gnt_id_o : last_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= 1'b1;
        else         last_q <= last_d;
    end

endmodule

// File: rtl/spiflashctrl.sv
// Arbitrates two byte read/write requesters onto one SPI NOR flash, one 48-bit mode-0 frame each.
module spiflashctrl
    import spiflashctrl_pkg::*;
#(
    parameter int unsigned CLKDIV = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    spiflashctrl_if.slave  bus,
    output logic           SCK,
    output logic           CS,
    output logic           MOSI,
    input  logic           MISO
);

    localparam logic [7:0] HLAST = 8'(CLKDIV - 1);

    state_e                         state_q, state_d;
    logic [7:0]                     hcnt_q, hcnt_d;
    logic [5:0]                     pcnt_q, pcnt_d;
    logic [SPIFLASH_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]                     rx_q, rx_d;
    logic [7:0]                     rdata_q, rdata_d;
    logic [1:0]                     rspv_q, rspv_d;
    logic                           sck_q, sck_d;
    logic                           id_q, id_d;
    logic                           wr_q, wr_d;
    logic                           gnt_id, accept, hdone;
    logic [1:0]                     ready;

    spiflashctrl_rrarb u_arb (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .en_i        (state_q == ST_IDLE),
        .req_valid_i (bus.ReqValid),
        .gnt_id_o    (gnt_id),
        .req_ready_o (ready)
    );

    assign accept = |ready;
    assign hdone  = (hcnt_q == HLAST);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rspv_d  = '0;
        sck_d   = sck_q;
        id_d    = id_q;
        wr_d    = wr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    hcnt_d  = '0;
                    id_d    = gnt_id;
                    wr_d    = bus.ReqWrite[gnt_id];
                    shreg_d = spiflash_frame(bus.ReqAdr[gnt_id], bus.ReqWrite[gnt_id],
                                             bus.ReqWData[gnt_id]);
                end
            end
            ST_SETUP: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hdone) begin
                    state_d = ST_SHIFT;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                    sck_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hdone) begin
                    hcnt_d = '0;
                    // Falling edge: advance MOSI and sample MISO for the data byte.
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        shreg_d = {shreg_q[SPIFLASH_FRAME_BITS-2:0], 1'b0};
                        if (pcnt_q >= 6'd40) rx_d = {rx_q[6:0], MISO};
                    end else if (pcnt_q == 6'd47) begin
                        state_d = ST_HOLD;
                    end else begin
                        sck_d  = 1'b1;
                        pcnt_d = pcnt_q + 6'd1;
                    end
                end
            end
            ST_HOLD: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hdone) begin
                    state_d      = ST_GAP;
                    hcnt_d       = '0;
                    rspv_d[id_q] = 1'b1;
                    rdata_d      = wr_q ? 8'h00 : rx_q;
                end
            end
            ST_GAP: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hdone) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            rspv_q  <= '0;
            sck_q   <= 1'b0;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rspv_q  <= rspv_d;
            sck_q   <= sck_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
        end
    end

    // CS also drops in the accept cycle so the inter-frame CS-high time is exactly the GAP.
    assign CS   = ~(accept | ((state_q != ST_IDLE) && (state_q != ST_GAP)));
    assign SCK  = sck_q;
    assign MOSI = shreg_q[SPIFLASH_FRAME_BITS-1];

    assign bus.ReqReady = ready;
    assign bus.RspValid = rspv_q;
    assign bus.RspRData = rdata_q;

endmodule

// File: tb/tb_spiflashctrl.sv
// Bench for spiflashctrl: device model on the SPI pins, reference memory for expected read data.
module tb_spiflashctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic SCK, CS, MOSI;
    logic MISO = 1'b0;
    logic SCK3, CS3, MOSI3;
    logic MISO3 = 1'b0;
    int   cyc = 0;
    int   rsp_total = 0;
    int   nvec = 0;
    int   nerr = 0;

    spiflashctrl_if bif ();
    spiflashctrl_if bif3 ();

    spiflashctrl #(.CLKDIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif),
        .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
    );

    spiflashctrl #(.CLKDIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bif3),
        .SCK(SCK3), .CS(CS3), .MOSI(MOSI3), .MISO(MISO3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (|bif.RspValid) rsp_total <= rsp_total + 1;

    // Flash contents before any write, shared by device and reference.
    function automatic logic [7:0] mem_init(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // ---------------- device model (mode 0, write commits on next frame's first rise)
    logic [47:0] dev_sh  = '0;
    int          dev_n   = 0;
    logic [7:0]  dev_out = '0;
    logic        pend_v  = 1'b0;
    logic [31:0] pend_a  = '0;
    logic [7:0]  pend_d  = '0;
    bit          cs_bad  = 1'b0;
    logic [7:0]  dev_mem [logic [31:0]];

    always @(posedge SCK or negedge CS) begin
        if (!SCK) dev_n = 0;
        else begin
            if (CS) cs_bad = 1'b1;
            if (dev_n == 0 && pend_v) begin
                dev_mem[pend_a] = pend_d;
                pend_v = 1'b0;
            end
            dev_sh = {dev_sh[46:0], MOSI};
            dev_n++;
            if (dev_n == 48 && dev_sh[15:8] == 8'h02) begin
                pend_v = 1'b1;
                pend_a = dev_sh[47:16];
                pend_d = dev_sh[7:0];
            end
        end
    end

    always @(negedge SCK) begin
        if (dev_n == 40 && dev_sh[7:0] == 8'h01) begin
            dev_out = dev_mem.exists(dev_sh[39:8]) ? dev_mem[dev_sh[39:8]] : mem_init(dev_sh[39:8]);
            MISO = dev_out[7];
        end else if (dev_n > 40 && dev_n < 48) MISO = dev_out[3'(47 - dev_n)];
        else MISO = 1'b0;
    end

    // ---------------- reference: a byte memory, every completed write visible to later reads
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic wr, input logic [31:0] adr, input logic [7:0] wd);
        bif.ReqWrite[id] = wr;
        bif.ReqAdr[id]   = adr;
        bif.ReqWData[id] = wd;
        bif.ReqValid[id] = 1'b1;
    endtask

    // Waits for the accept, then for the response; H=2 so the response is 197 cycles later.
    task automatic await_frame(input int id, input logic wr, input logic [31:0] adr, input logic [7:0] wd);
        int         t0;
        bit         got;
        logic [7:0] exp;
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            #1;
            if (|bif.ReqReady) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("grant", 64'(bif.ReqReady), 64'(2'b01 << id));
        t0  = cyc;
        exp = wr ? 8'h00 : ref_rd(adr);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (|bif.RspValid) begin got = 1'b1; break; end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("rsp_latency", 64'(cyc - t0), 64'd197);
        chk("rsp_owner", 64'(bif.RspValid), 64'(2'b01 << id));
        chk("rsp_rdata", 64'(bif.RspRData), 64'(exp));
        if (wr) ref_mem[adr] = wd;
    endtask

    int          id, sel, n, cs_hi, rsp0;
    int          t_acc [3];
    logic        wr;
    logic [31:0] adr;
    logic [7:0]  wd;

    initial begin
        t_acc = '{0, 0, 0};
        reset_n = 1'b0;
        bif.ReqValid  = 2'b11;
        bif.ReqWrite  = '0;
        bif.ReqAdr    = '0;
        bif.ReqWData  = '0;
        bif3.ReqValid = '0;
        bif3.ReqWrite = '0;
        bif3.ReqAdr   = '0;
        bif3.ReqWData = '0;
        #3;
        chk("rst_cs", 64'(CS), 64'd1);
        chk("rst_sck", 64'(SCK), 64'd0);
        chk("rst_mosi", 64'(MOSI), 64'd0);
        chk("rst_ready", 64'(bif.ReqReady), 64'd0);
        chk("rst_rspv", 64'(bif.RspValid), 64'd0);
        chk("rst_rdata", 64'(bif.RspRData), 64'd0);
        bif.ReqValid = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // frame format: requester 1 write
        drive(1, 1'b1, 32'h0000_0123, 8'hC3);
        await_frame(1, 1'b1, 32'h0000_0123, 8'hC3);
        bif.ReqValid = '0;
        chk("fmt_rises", 64'(dev_n), 64'd48);
        chk("fmt_mosi", 64'(dev_sh), 64'h0000_0123_02C3);
        chk("fmt_cs_low", 64'(cs_bad), 64'd0);

        // write then read back through the device
        drive(0, 1'b1, 32'h10, 8'h5A);
        await_frame(0, 1'b1, 32'h10, 8'h5A);
        bif.ReqValid = '0;
        drive(0, 1'b0, 32'h10, 8'hFF);
        await_frame(0, 1'b0, 32'h10, 8'hFF);
        bif.ReqValid = '0;
        chk("rd_cmd", 64'(dev_sh[15:8]), 64'h01);
        chk("rd_mosi_data", 64'(dev_sh[7:0]), 64'h00);

        // randomized single requests
        for (int k = 0; k < 10; k++) begin
            id  = int'($urandom_range(1, 0));
            wr  = 1'($urandom_range(1, 0));
            sel = int'($urandom_range(3, 0));
            adr = (sel == 0) ? 32'h10 : (sel == 1) ? 32'h20 : (sel == 2) ? 32'hFFFF_FFFF : $urandom;
            wd  = 8'($urandom);
            drive(id, wr, adr, wd);
            await_frame(id, wr, adr, wd);
            bif.ReqValid = '0;
        end

        // tie arbitration from reset: 0,1,0,1
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        adr = $urandom;
        wd  = 8'($urandom);
        drive(0, 1'b1, adr, wd);
        drive(1, 1'b0, adr, 8'h00);
        for (int k = 0; k < 4; k++) await_frame(k % 2, (k % 2) == 0, adr, wd);
        bif.ReqValid = '0;

        // mid-frame reset
        @(negedge clk);
        drive(0, 1'b0, 32'h20, 8'h00);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dev_n >= 20) break;
        end
        chk("mid_reached", 64'(dev_n >= 20), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_cs", 64'(CS), 64'd1);
        chk("mid_sck", 64'(SCK), 64'd0);
        chk("mid_mosi", 64'(MOSI), 64'd0);
        chk("mid_ready", 64'(bif.ReqReady), 64'd0);
        chk("mid_rspv", 64'(bif.RspValid), 64'd0);
        rsp0 = rsp_total;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mid_ready_back", 64'(bif.ReqReady), 64'd1);
        chk("mid_no_rsp", 64'(rsp_total - rsp0), 64'd0);
        await_frame(0, 1'b0, 32'h20, 8'h00);
        bif.ReqValid = '0;

        // back-to-back on the CLKDIV=3 instance
        @(negedge clk);
        bif3.ReqWrite    = 2'b01;
        bif3.ReqAdr[0]   = $urandom;
        bif3.ReqWData[0] = 8'($urandom);
        bif3.ReqValid    = 2'b01;
        n     = 0;
        cs_hi = 0;
        for (int i = 0; i < 1500 && n < 3; i++) begin
            #1;
            if (bif3.ReqReady[0]) begin
                t_acc[n] = cyc;
                n++;
            end else if (n == 1 && CS3) cs_hi++;
            @(negedge clk);
        end
        bif3.ReqValid = '0;
        chk("b2b_accepts", 64'(n), 64'd3);
        chk("b2b_period0", 64'(t_acc[1] - t_acc[0]), 64'd298);
        chk("b2b_period1", 64'(t_acc[2] - t_acc[1]), 64'd298);
        chk("b2b_cs_high", 64'(cs_hi), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
